cali_ram_arbiter: RTL and testbench

Shares one single-port calibration RAM (2 banks x 512 x 16) between the calibration datapath read port and a host Avalon-MM slave. The datapath always reads the active bank with priority. The host reads and writes the shadow bank in idle RAM cycles. A host-requested bank swap is applied only between frames, so every frame is calibrated with one consistent coefficient set.

---
 rtl/cali_ram_arbiter.sv | 130 +++++++++++++
 tb/tb_cali_ram_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cali_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cali_ram_arbiter: shares one calibration RAM between the datapath reader   |
// | and a host shadow-bank port; bank swaps are deferred to frame gaps.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cali_ram_arbiter #(
   parameter int ADDR_W        = 9,
   parameter int DATA_W        = 16,
   parameter int FRAME_TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] algo_address,
   input  logic              algo_clken,
   output logic [DATA_W-1:0] algo_cali_fac,
   input  logic              st_valid,
   input  logic              st_ready,
   input  logic              st_sop,
   input  logic              st_eop,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [DATA_W-1:0] avs_writedata,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_readdatavalid,
   output logic              avs_waitrequest,
   input  logic              swap_req,
   output logic              swap_pending,
   output logic              active_bank,
   output logic [ADDR_W:0]   ram_address,
   output logic              ram_wren,
   output logic              ram_clken,
   output logic [DATA_W-1:0] ram_wrdata,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int TMR_W = ($clog2(FRAME_TIMEOUT) < 1) ? 1 : $clog2(FRAME_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FRAME_TIMEOUT - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              bank_q, bank_d;
   logic              pend_q, pend_d;
   logic              algo_rd_q, host_rd_q;
   logic              host_rd_d;
   logic [DATA_W-1:0] algo_hold_q, host_hold_q;

   logic beat, apply, algo_grant, host_grant;

   assign beat = st_valid & st_ready;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (beat && st_sop && !st_eop) state_d = FRAME;
         end
         FRAME: begin
            if (beat) begin
               tmr_d = '0;
               if (st_eop) state_d = IDLE;
            end else if (tmr_q == TMR_LAST) begin
               tmr_d   = '0;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // A swap waits for a frame gap that is not starting a new frame and has no datapath read.
   assign apply     = pend_q & (state_q == IDLE) & ~(beat & st_sop) & ~algo_clken;
   assign pend_d    = (pend_q & ~apply) | swap_req;
   assign bank_d    = bank_q ^ apply;
   assign host_rd_d = ~algo_clken & avs_read & ~avs_write;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         bank_q      <= 1'b0;
         pend_q      <= 1'b0;
         algo_rd_q   <= 1'b0;
         host_rd_q   <= 1'b0;
         algo_hold_q <= '0;
         host_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         bank_q    <= bank_d;
         pend_q    <= pend_d;
         algo_rd_q <= algo_clken;
         host_rd_q <= host_rd_d;
         if (algo_rd_q) algo_hold_q <= ram_q;
         if (host_rd_q) host_hold_q <= ram_q;
      end
   end

   // Grants are gated by reset so every RAM-side output is quiet while held in reset.
   assign algo_grant = rst & algo_clken;
   assign host_grant = rst & ~algo_clken & (avs_read | avs_write);

   assign ram_clken   = algo_grant | host_grant;
   assign ram_wren    = host_grant & avs_write;
   assign ram_wrdata  = ram_wren ? avs_writedata : '0;
   assign ram_address = algo_grant ? {bank_q, algo_address} :
                        host_grant ? {~bank_q, avs_address} : '0;

   assign avs_waitrequest   = ~rst | algo_clken;
   assign avs_readdatavalid = host_rd_q;
   assign avs_readdata      = host_rd_q ? ram_q : host_hold_q;
   assign algo_cali_fac     = algo_rd_q ? ram_q : algo_hold_q;
   assign swap_pending      = pend_q;
   assign active_bank       = bank_q;

endmodule
`default_nettype wire

// File: tb/tb_cali_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cali_ram_arbiter: directed bench with a behavioural 1-cycle RAM model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cali_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  algo_address;
   logic        algo_clken;
   logic [15:0] algo_cali_fac;
   logic        st_valid, st_ready, st_sop, st_eop;
   logic [8:0]  avs_address;
   logic        avs_read, avs_write;
   logic [15:0] avs_writedata, avs_readdata;
   logic        avs_readdatavalid, avs_waitrequest;
   logic        swap_req, swap_pending, active_bank;
   logic [9:0]  ram_address;
   logic        ram_wren, ram_clken;
   logic [15:0] ram_wrdata;
   logic [15:0] ram_q;

   logic [15:0] mem [0:1023];
   int unsigned tests = 0;
   int unsigned fails = 0;

   always #5 clk = ~clk;

   cali_ram_arbiter dut (
      .clk(clk), .rst(rst),
      .algo_address(algo_address), .algo_clken(algo_clken), .algo_cali_fac(algo_cali_fac),
      .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
      .swap_req(swap_req), .swap_pending(swap_pending), .active_bank(active_bank),
      .ram_address(ram_address), .ram_wren(ram_wren), .ram_clken(ram_clken),
      .ram_wrdata(ram_wrdata), .ram_q(ram_q)
   );

   always @(posedge clk) begin
      if (ram_clken) begin
         if (ram_wren) mem[ram_address] <= ram_wrdata;
         ram_q <= mem[ram_address];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      algo_clken = 0; algo_address = '0;
      st_valid = 0; st_ready = 0; st_sop = 0; st_eop = 0;
      avs_read = 0; avs_write = 0; avs_address = '0; avs_writedata = '0;
      swap_req = 0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      for (int k = 0; k < 1024; k++) mem[k] = (k < 512) ? 16'(16'h1000 + k) : 16'h0000;
      ram_q = '0;
      idle_inputs();
      rst = 0;
      smp();
      check("rst_active_bank", 32'(active_bank), 0);
      check("rst_waitrequest", 32'(avs_waitrequest), 1);
      check("rst_rdvalid", 32'(avs_readdatavalid), 0);
      check("rst_ram_clken", 32'(ram_clken), 0);
      check("rst_swap_pending", 32'(swap_pending), 0);
      check("rst_algo_fac", 32'(algo_cali_fac), 0);
      tick();
      rst = 1;
      tick();

      // Host fills the shadow bank with no datapath traffic.
      cnt = 0;
      for (int a = 0; a < 512; a++) begin
         avs_write = 1; avs_address = 9'(a); avs_writedata = 16'h0003;
         smp();
         if (!avs_waitrequest && ram_wren && ram_address == 10'(32'h200 + a) && ram_wrdata == 16'h0003) cnt++;
         tick();
      end
      idle_inputs();
      check("t1_writes_ok", 32'(cnt), 512);
      avs_read = 1; avs_address = 9'd0;
      smp(); check("t1_rd0_addr", 32'(ram_address), 32'h200);
      check("t1_rd0_wait", 32'(avs_waitrequest), 0);
      tick(); idle_inputs();
      smp(); check("t1_rd0_valid", 32'(avs_readdatavalid), 1);
      check("t1_rd0_data", 32'(avs_readdata), 32'h3);
      tick();
      avs_read = 1; avs_address = 9'd511;
      smp(); check("t1_rd511_addr", 32'(ram_address), 32'h3FF);
      tick(); idle_inputs();
      smp(); check("t1_rd511_data", 32'(avs_readdata), 32'h3);
      tick();
      // Read and write together: the write wins and no read data returns.
      avs_read = 1; avs_write = 1; avs_address = 9'd10; avs_writedata = 16'hBEEF;
      smp(); check("rw_wren", 32'(ram_wren), 1);
      check("rw_addr", 32'(ram_address), 32'h20A);
      tick(); idle_inputs();
      smp(); check("rw_no_valid", 32'(avs_readdatavalid), 0);
      tick();
      avs_read = 1; avs_address = 9'd10;
      tick(); idle_inputs();
      smp(); check("rw_readback", 32'(avs_readdata), 32'hBEEF);
      tick();

      // Datapath holds the RAM for 10 cycles while the host waits to write.
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         algo_clken = 1; algo_address = 9'(i);
         avs_write = 1; avs_address = 9'd20; avs_writedata = 16'h1234;
         smp();
         if (avs_waitrequest && !ram_wren && ram_address == 10'(i) &&
             (i == 0 || algo_cali_fac == 16'(16'h1000 + i - 1))) cnt++;
         tick();
      end
      check("t2_stall_reads", 32'(cnt), 10);
      algo_clken = 0;
      smp(); check("t2_free_wait", 32'(avs_waitrequest), 0);
      check("t2_free_addr", 32'(ram_address), 32'h214);
      check("t2_last_fac", 32'(algo_cali_fac), 32'h1009);
      tick(); idle_inputs();
      smp(); check("t2_fac_hold", 32'(algo_cali_fac), 32'h1009);
      tick();

      // 163-beat frame with swap requests inside it.
      st_valid = 1; st_ready = 1; st_sop = 1;
      tick();
      cnt = 0;
      for (int b = 2; b <= 163; b++) begin
         st_sop = 0; st_eop = (b == 163); swap_req = (b == 2 || b == 50);
         smp();
         if (b >= 3 && swap_pending && !active_bank) cnt++;
         tick();
      end
      idle_inputs();
      check("t3_frame_hold", 32'(cnt), 161);
      smp(); check("t3_apply_cycle_bank", 32'(active_bank), 0);
      check("t3_apply_cycle_pend", 32'(swap_pending), 1);
      tick();
      smp(); check("t3_swapped_bank", 32'(active_bank), 1);
      check("t3_swapped_pend", 32'(swap_pending), 0);
      tick();
      smp(); check("t3_single_swap", 32'(active_bank), 1);
      algo_clken = 1; algo_address = 9'd7;
      smp(); check("t3_algo_addr", 32'(ram_address), 32'h207);
      tick(); idle_inputs();
      smp(); check("t3_algo_data", 32'(algo_cali_fac), 32'h3);
      tick();

      // Swap in IDLE, re-armed by a request landing on the apply cycle.
      swap_req = 1;
      smp(); check("t4_pend_before", 32'(swap_pending), 0);
      tick();
      avs_write = 1; avs_address = 9'd30; avs_writedata = 16'hAAAA;
      smp(); check("t4_apply_pend", 32'(swap_pending), 1);
      check("t4_host_preswap", 32'(ram_address), 32'h01E);
      tick(); idle_inputs();
      smp(); check("t4_rearm_bank", 32'(active_bank), 0);
      check("t4_rearm_pend", 32'(swap_pending), 1);
      tick();
      smp(); check("t4_second_bank", 32'(active_bank), 1);
      check("t4_second_pend", 32'(swap_pending), 0);
      avs_read = 1; avs_address = 9'd30;
      smp(); check("t4_shadow_addr", 32'(ram_address), 32'h01E);
      tick(); idle_inputs();
      smp(); check("t4_shadow_data", 32'(avs_readdata), 32'hAAAA);
      algo_clken = 1; algo_address = 9'd5;
      smp(); check("t4_algo_addr5", 32'(ram_address), 32'h205);
      tick(); idle_inputs();
      smp(); check("t4_algo_data5", 32'(algo_cali_fac), 32'h3);
      tick();

      // SOP without EOP: timeout returns to IDLE, then the pending swap applies.
      st_valid = 1; st_ready = 1; st_sop = 1;
      tick();
      idle_inputs(); swap_req = 1;
      tick();
      swap_req = 0;
      cnt = 0;
      for (int c = 0; c < 4096; c++) begin
         smp();
         if (active_bank && swap_pending) cnt++;
         tick();
      end
      check("t5_wait_timeout", 32'(cnt), 4096);
      smp(); check("t5_bank_after", 32'(active_bank), 0);
      check("t5_pend_after", 32'(swap_pending), 0);
      tick();

      // Reset mid-frame with a pending swap and an outstanding host read.
      swap_req = 1;
      tick(); swap_req = 0;
      tick();
      smp(); check("t6_pre_bank", 32'(active_bank), 1);
      st_valid = 1; st_ready = 1; st_sop = 1;
      tick(); idle_inputs(); swap_req = 1;
      tick(); swap_req = 0;
      avs_read = 1; avs_address = 9'd3;
      smp(); check("t6_pre_pend", 32'(swap_pending), 1);
      tick();
      rst = 0; idle_inputs();
      #1;
      check("t6_rst_valid", 32'(avs_readdatavalid), 0);
      check("t6_rst_bank", 32'(active_bank), 0);
      check("t6_rst_pend", 32'(swap_pending), 0);
      check("t6_rst_wait", 32'(avs_waitrequest), 1);
      cnt = 0;
      for (int c = 0; c < 2; c++) begin
         tick(); if (avs_readdatavalid) cnt++;
      end
      rst = 1;
      for (int c = 0; c < 4; c++) begin
         smp(); if (avs_readdatavalid || active_bank || swap_pending) cnt++;
         tick();
      end
      check("t6_quiet_after", 32'(cnt), 0);
      avs_write = 1; avs_address = 9'd1; avs_writedata = 16'h5555;
      smp(); check("t6_resume_addr", 32'(ram_address), 32'h201);
      check("t6_resume_wait", 32'(avs_waitrequest), 0);
      tick(); idle_inputs();
      avs_read = 1; avs_address = 9'd1;
      tick(); idle_inputs();
      smp(); check("t6_resume_valid", 32'(avs_readdatavalid), 1);
      check("t6_resume_data", 32'(avs_readdata), 32'h5555);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
